// File: rtl/neg_pipe_pkg.sv
// neg_pipe_stage shared types: operand/result layouts and field helpers.
// Optional feature macro: NEG_PIPE_ABS_EN (see neg_pipe_stage.sv).
package neg_pipe_pkg;

    localparam int DATA_W = 128;
    localparam int NF     = 9;
    localparam int OP_W   = 90;
    localparam int B_OFF  = 0;
    localparam int A_OFF  = 45;
    localparam int OA_OFF = 0;
    localparam int OB_OFF = 45;
    localparam int OC_W   = 6;
    localparam int OC_OFF = 90;
    localparam int OVF_W  = 9;
    localparam int FLD_W  = 45;

    // Field N is N bits wide and starts at N*(N-1)/2 within its group.
    function automatic int fld_off(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    function automatic logic [8:0] fmask(input int n);
        return 9'((1 << n) - 1);
    endfunction

    typedef struct packed {
        logic [8:0] a9;
        logic [7:0] a8;
        logic [6:0] a7;
        logic [5:0] a6;
        logic [4:0] a5;
        logic [3:0] a4;
        logic [2:0] a3;
        logic [1:0] a2;
        logic       a1;
        logic [8:0] b9;
        logic [7:0] b8;
        logic [6:0] b7;
        logic [5:0] b6;
        logic [4:0] b5;
        logic [3:0] b4;
        logic [2:0] b3;
        logic [1:0] b2;
        logic       b1;
    } operands_t;

    typedef struct packed {
        logic [1:0]       pad;
        logic [OC_W-1:0]  oc6;
        logic [OC_W-1:0]  oc5;
        logic [OC_W-1:0]  oc4;
        logic [OC_W-1:0]  oc3;
        logic [OC_W-1:0]  oc2;
        logic [OC_W-1:0]  oc1;
        logic [FLD_W-1:0] ob;
        logic [FLD_W-1:0] oa;
    } results_t;

endpackage

// File: rtl/neg_pipe_slot.sv
// Generic valid/ready register slice; loads whenever empty or draining.
// Data only updates when the upstream word is valid.
module neg_pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_ld;

    assign w_ld    = !r_valid || i_ready;
    assign o_ready = w_ld;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_ld) begin
            r_valid <= i_valid;
            if (i_valid)
                r_data <= i_data;
        end
    end

endmodule

// File: rtl/neg_pipe_stage.sv
// Two-stage pipelined unary-minus datapath over packed un_minus fields.
// Optional NEG_PIPE_ABS_EN adds abs_mode: signed fields yield |bN|.
module neg_pipe_stage
    import neg_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef NEG_PIPE_ABS_EN
    input  logic              abs_mode,
`endif
    output logic [127:0]      out_data,
    output logic [8:0]        out_ovf,
    output logic [CNT_W-1:0]  xfer_cnt
);

`ifdef NEG_PIPE_ABS_EN
    localparam int S1_W = OP_W + 1;
`else
    localparam int S1_W = OP_W;
`endif
    localparam int S2_W = DATA_W + OVF_W;

    logic [S1_W-1:0]  w_s1_d;
    logic [S1_W-1:0]  w_s1_q;
    logic             w_s1_valid;
    logic             w_s2_ready;
    logic [S2_W-1:0]  w_s2_q;
    operands_t        w_op;
    logic [OP_W-1:0]  w_opv;
    logic             w_abs;
    results_t         w_res;
    logic [OVF_W-1:0] w_ovf;
    logic [CNT_W-1:0] r_cnt;

`ifdef NEG_PIPE_ABS_EN
    assign w_s1_d = {abs_mode, in_data[OP_W-1:0]};
    assign w_abs  = w_s1_q[OP_W];
`else
    assign w_s1_d = in_data[OP_W-1:0];
    assign w_abs  = 1'b0;
`endif

    assign w_op  = w_s1_q[OP_W-1:0];
    assign w_opv = w_s1_q[OP_W-1:0];

    neg_pipe_slot #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_s1_d),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_q)
    );

    always_comb begin
        logic [8:0] w_a;
        logic [8:0] w_b;
        logic [8:0] w_na;
        logic [8:0] w_nb;
        logic       w_flip;
        w_res = '0;
        w_ovf = '0;
        for (int n = 1; n <= NF; n++) begin
            w_a  = 9'(w_opv >> (A_OFF + fld_off(n))) & fmask(n);
            w_b  = 9'(w_opv >> (B_OFF + fld_off(n))) & fmask(n);
            w_na = (~w_a + 9'd1) & fmask(n);
            w_nb = (~w_b + 9'd1) & fmask(n);
            // abs_mode leaves non-negative signed fields untouched
            w_flip = !w_abs || w_b[n-1];
            if (!w_flip)
                w_nb = w_b;
            w_res.oa = w_res.oa | (FLD_W'(w_na) << fld_off(n));
            w_res.ob = w_res.ob | (FLD_W'(w_nb) << fld_off(n));
            w_ovf[n-1] = (w_b == (9'd1 << (n - 1)));
        end
        w_res.oc1 = ~w_op.a9[5:0] + 6'd1;
        w_res.oc2 = ~w_op.a9[5:0] + 6'd1;
        w_res.oc3 = ~{3'b000, w_op.a3} + 6'd1;
        w_res.oc4 = ~{{3{w_op.b3[2]}}, w_op.b3} + 6'd1;
        w_res.oc5 = ~{5'b00000, w_op.a1} + 6'd1;
        w_res.oc6 = ~{6{w_op.b1}} + 6'd1;
    end

    neg_pipe_slot #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_ovf, w_res}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_q)
    );

    assign out_data = w_s2_q[DATA_W-1:0];
    assign out_ovf  = w_s2_q[S2_W-1:DATA_W];
    assign xfer_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (in_valid && in_ready)
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_neg_pipe_stage.sv
// Scoreboard bench for neg_pipe_stage: directed vectors, backpressure,
// counter wrap and mid-stream reset.
module tb_neg_pipe_stage;

    typedef struct packed {
        logic [127:0] d;
        logic [8:0]   o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [8:0]   out_ovf;
    logic [15:0]  xfer_cnt;
`ifdef NEG_PIPE_ABS_EN
    logic         abs_mode;
`endif

    int checks;
    int errors;
    int exp_cnt;
    bit mon_en;
    bit hold_v;
    logic [127:0] hold_d;
    logic [8:0]   hold_o;
    exp_t q[$];

    logic [127:0] vin  [9];
    logic [127:0] vexp [9];
    logic [8:0]   vovf [9];

    neg_pipe_stage #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef NEG_PIPE_ABS_EN
        .abs_mode  (abs_mode),
`endif
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: pop on every output handshake, check hold under stall.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h want none",
                             out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_ovf", 128'(out_ovf), 128'(e.o));
                end
            end
            if (out_valid && !out_ready) begin
                if (hold_v) begin
                    chk("hold_data", out_data, hold_d);
                    chk("hold_ovf", 128'(out_ovf), 128'(hold_o));
                end
                hold_v = 1'b1;
                hold_d = out_data;
                hold_o = out_ovf;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [127:0] ed,
                        input logic [8:0] eo);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 want 1");
        end else begin
            q.push_back({ed, eo});
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vin[0] = 128'd0;            vexp[0] = 128'd0;            vovf[0] = 9'h000;
        vin[1] = 128'd1;
        vexp[1] = (128'd1 << 120) | (128'd1 << 45);                  vovf[1] = 9'h001;
        vin[2] = 128'd1 << 45;
        vexp[2] = (128'h3F << 114) | 128'd1;                         vovf[2] = 9'h000;
        vin[3] = 128'h4 << 3;
        vexp[3] = (128'd1 << 50) | (128'h4 << 108);                  vovf[3] = 9'h004;
        vin[4] = 128'h4 << 48;
        vexp[4] = (128'h4 << 3) | (128'h3C << 102);                  vovf[4] = 9'h000;
        vin[5] = 128'h100 << 36;
        vexp[5] = 128'h100 << 81;                                    vovf[5] = 9'h100;
        vin[6] = 128'd1 << 81;
        vexp[6] = (128'h1FF << 36) | (128'h3F << 90) | (128'h3F << 96);
        vovf[6] = 9'h000;
        vin[7] = ~128'd0 << 90;     vexp[7] = 128'd0;            vovf[7] = 9'h000;
        vin[8] = 128'd2;            vexp[8] = 128'd3 << 46;      vovf[8] = 9'h000;
    end

    initial begin
        int base;
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        mon_en    = 1'b1;
        hold_v    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef NEG_PIPE_ABS_EN
        abs_mode  = 1'b0;
`endif
        rst_n = 1'b0;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_xfer_cnt", 128'(xfer_cnt), 128'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        send(vin[0], vexp[0], vovf[0]);
        chk("lat1_cnt", 128'(xfer_cnt), 128'd1);
        chk("lat1_valid", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        chk("lat2_valid", 128'(out_valid), 128'd1);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 1; i < 9; i++)
            send(vin[i], vexp[i], vovf[i]);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: 5 words, out_ready low for 4 cycles
        base = int'(xfer_cnt);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i < 6; i++)
                    send(vin[i], vexp[i], vovf[i]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_accepts", 128'(xfer_cnt - 16'(base)), 128'd2);
                chk("bp_in_ready", 128'(in_ready), 128'd0);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 128'(q.size()), 128'd0);
        chk("bp_xfer_cnt", 128'(xfer_cnt), 128'(exp_cnt));

        // Counter wrap
        do_reset();
        mon_en   = 1'b0;
        in_data  = '0;
        in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("cnt_ffff", 128'(xfer_cnt), 128'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        send(vin[3], vexp[3], vovf[3]);
        chk("cnt_wrap", 128'(xfer_cnt), 128'd0);
        repeat (4) @(posedge clk);
        #1;

        // Mid-stream reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vin[1];
        repeat (3) @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mrst_valid", 128'(out_valid), 128'd0);
        chk("mrst_data", out_data, 128'd0);
        chk("mrst_ovf", 128'(out_ovf), 128'd0);
        chk("mrst_cnt", 128'(xfer_cnt), 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_in_ready", 128'(in_ready), 128'd1);
        chk("mrst_no_stale1", 128'(out_valid), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_no_stale2", 128'(out_valid), 128'd0);
        mon_en = 1'b1;
        send(vin[8], vexp[8], vovf[8]);
        repeat (4) @(posedge clk);
        #1;
        chk("final_q_empty", 128'(q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
